// File: rtl/se61_pkg.sv
// Shared constants and helpers for the three-input truth-table function unit.
// Table bit {a,b,c} holds f for that minterm.
package se61_pkg;

    localparam logic [7:0] TT_MAJORITY = 8'hE8;
    localparam logic [7:0] TT_AND3     = 8'h80;
    localparam logic [7:0] TT_OR3      = 8'hFE;
    localparam logic [7:0] TT_XOR3     = 8'h96;

    // a is the MSB, so idx = 4a + 2b + c.
    function automatic logic [2:0] minterm_idx(input logic a, input logic b, input logic c);
        return {a, b, c};
    endfunction

endpackage

// File: rtl/se61_lut8.sv
// 8:1 selection of one truth-table bit by minterm index.
module se61_lut8 (
    input  logic [7:0] tt,
    input  logic [2:0] idx,
    output logic       f
);

    assign f = tt[idx];

endmodule

// File: rtl/se61_unit.sv
// Three-input Boolean function unit with a reprogrammable 8-entry truth table,
// a zero-latency result and a one-cycle registered result with a valid flag.
module se61_unit
    import se61_pkg::*;
#(
    parameter logic [7:0] TT_INIT = TT_MAJORITY
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       in_valid,
    input  logic       tt_load,
    input  logic [7:0] tt_data,
    output logic       f,
    output logic       f_q,
    output logic       f_valid,
    output logic [7:0] tt_q
);

    logic [2:0] idx;
    logic       f_comb;
    logic [7:0] tt_d;
    logic       f_d;
    logic       f_valid_d;
    logic       f_valid_q;

    assign idx = minterm_idx(a, b, c);

    se61_lut8 u_lut (
        .tt  (tt_q),
        .idx (idx),
        .f   (f_comb)
    );

    // Valid semantics: in_valid is sampled on each rising edge; f_valid is high
    // for exactly the cycles after an edge that captured a qualified a/b/c.
    // There is no back-pressure. f_q is computed from the pre-edge table, so a
    // table load in the same cycle only affects results from the next cycle on.
    always_comb begin
        tt_d      = tt_q;
        f_d       = f_q;
        f_valid_d = 1'b0;
        if (tt_load) begin
            tt_d = tt_data;
        end
        if (in_valid) begin
            f_d       = f_comb;
            f_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt_q      <= TT_INIT;
            f_q       <= 1'b0;
            f_valid_q <= 1'b0;
        end else begin
            tt_q      <= tt_d;
            f_q       <= f_d;
            f_valid_q <= f_valid_d;
        end
    end

    assign f       = f_comb;
    assign f_valid = f_valid_q;

endmodule

// File: tb/tb_se61_unit.sv
// Directed bench for se61_unit: reset, combinational and registered paths,
// table reload ordering, valid hold behaviour and asynchronous reset.
module tb_se61_unit;

  logic       clk;
  logic       rst_n;
  logic       a, b, c;
  logic       in_valid;
  logic       tt_load;
  logic [7:0] tt_data;
  logic       f;
  logic       f_q;
  logic       f_valid;
  logic [7:0] tt_q;

  int tests_run;
  int tests_failed;

  se61_unit #(.TT_INIT(8'hE8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .c        (c),
    .in_valid (in_valid),
    .tt_load  (tt_load),
    .tt_data  (tt_data),
    .f        (f),
    .f_q      (f_q),
    .f_valid  (f_valid),
    .tt_q     (tt_q)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_abc(input logic [2:0] v, input logic vld);
    a = v[2];
    b = v[1];
    c = v[0];
    in_valid = vld;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_abc(3'b000, 1'b0);
    tt_load = 1'b0;
    tt_data = 8'h00;
    #12;
    tests_run++;
    if (tt_q !== 8'hE8) begin
      tests_failed++;
      $display("FAIL reset_tt_q got %h want e8", tt_q);
    end
    tests_run++;
    if (f_q !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_f_q got %b want 0", f_q);
    end
    tests_run++;
    if (f_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_f_valid got %b want 0", f_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    drive_abc(3'b111, 1'b1);
    #1;
    tests_run++;
    if (f !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_f_111 got %b want 1", f);
    end
    tick();
    tests_run++;
    if (f_q !== 1'b1 || f_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_fq_111 got f_q=%b f_valid=%b want 1/1", f_q, f_valid);
    end
    #100;
    drive_abc(3'b101, 1'b1);
    #1;
    tests_run++;
    if (f !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_f_101 got %b want 1", f);
    end
    tick();
    tests_run++;
    if (f_q !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_fq_101 got %b want 1", f_q);
    end
    drive_abc(3'b001, 1'b1);
    #1;
    tests_run++;
    if (f !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_f_001 got %b want 0", f);
    end
    tick();
    tests_run++;
    if (f_q !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_fq_001 got %b want 0", f_q);
    end
  endtask

  task automatic test_sweep();
    // majority of a,b,c, listed for idx 0..7
    logic exp_maj [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      drive_abc(3'(i), 1'b1);
      #1;
      tests_run++;
      if (f !== exp_maj[i]) begin
        tests_failed++;
        $display("FAIL sweep_f idx=%0d got %b want %b", i, f, exp_maj[i]);
      end
      tick();
      tests_run++;
      if (f_q !== exp_maj[i] || f_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL sweep_fq idx=%0d got f_q=%b f_valid=%b want %b/1", i, f_q, f_valid, exp_maj[i]);
      end
    end
  endtask

  task automatic test_load();
    drive_abc(3'b111, 1'b1);
    tt_load = 1'b1;
    tt_data = 8'h96;
    tick();
    tt_load = 1'b0;
    tests_run++;
    if (f_q !== 1'b1 || tt_q !== 8'h96) begin
      tests_failed++;
      $display("FAIL load_xor3 got f_q=%b tt_q=%h want 1/96", f_q, tt_q);
    end
    drive_abc(3'b110, 1'b1);
    #1;
    tests_run++;
    if (f !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_f_110 got %b want 0", f);
    end
    tick();
    tests_run++;
    if (f_q !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_fq_110 got %b want 0", f_q);
    end
    // idx 2: xor3 gives 1, and3 gives 0 -> registered result must use the old table
    drive_abc(3'b010, 1'b1);
    tt_load = 1'b1;
    tt_data = 8'h80;
    tick();
    tt_load = 1'b0;
    tests_run++;
    if (f_q !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_old_table got f_q=%b want 1", f_q);
    end
    tests_run++;
    if (f !== 1'b0 || tt_q !== 8'h80) begin
      tests_failed++;
      $display("FAIL load_new_table got f=%b tt_q=%h want 0/80", f, tt_q);
    end
  endtask

  task automatic test_hold();
    drive_abc(3'b000, 1'b0);
    tick();
    tests_run++;
    if (f_valid !== 1'b0 || f_q !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_1 got f_q=%b f_valid=%b want 1/0", f_q, f_valid);
    end
    tick();
    tests_run++;
    if (f_valid !== 1'b0 || f_q !== 1'b1 || f !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_2 got f_q=%b f_valid=%b f=%b want 1/0/0", f_q, f_valid, f);
    end
  endtask

  task automatic test_async_reset();
    drive_abc(3'b111, 1'b1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (tt_q !== 8'hE8 || f_q !== 1'b0 || f_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset got tt_q=%h f_q=%b f_valid=%b want e8/0/0", tt_q, f_q, f_valid);
    end
    drive_abc(3'b011, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (f !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_reset_f got %b want 1", f);
    end
    tick();
    tests_run++;
    if (f_valid !== 1'b0 || f_q !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_idle got f_q=%b f_valid=%b want 0/0", f_q, f_valid);
    end
    in_valid = 1'b1;
    tick();
    tests_run++;
    if (f_valid !== 1'b1 || f_q !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_reset_first got f_q=%b f_valid=%b want 1/1", f_q, f_valid);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_sweep();
    test_load();
    test_hold();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
